// File: rtl/gsu_pkg.sv
// gsu_pkg: shared GSU cache constants, fill FSM state encoding and address helpers.
package gsu_pkg;

  localparam int LINE_BYTES = 16;
  localparam int NUM_LINES  = 32;

  // One-hot state encoding, 8 bits wide to match the core's FSMs
  typedef enum logic [7:0] {
    ST_IDLE  = 8'h01,
    ST_REQ   = 8'h02,
    ST_WAIT  = 8'h04,
    ST_WRITE = 8'h08,
    ST_DONE  = 8'h10,
    ST_DRAIN = 8'h20
  } fill_state_e;

  // Cache RAM byte address; only the low 9 bits of line+offset and cbr matter mod 512
  function automatic logic [8:0] cache_index(input logic [4:0] pc_line, input logic [3:0] cnt,
                                             input logic [8:0] cbr);
    return {pc_line, cnt} + cbr;
  endfunction

  // Line slot of a PC; cbr[3:0] is always zero so the offset never carries into the line
  function automatic logic [4:0] line_index(input logic [4:0] pc_line, input logic [4:0] cbr_line);
    return pc_line + cbr_line;
  endfunction

  function automatic logic [23:0] rom_addr(input logic [7:0] bank, input logic [11:0] pc_hi,
                                           input logic [3:0] cnt);
    return {bank, pc_hi, cnt};
  endfunction

endpackage

// File: rtl/gsu_cache_flags.sv
// gsu_cache_flags: per-line valid bits; flush beats any set, fill and SNES sets are OR-ed.
module gsu_cache_flags
  import gsu_pkg::*;
(
  input  logic                 clkin,
  input  logic                 rst_n,
  input  logic                 clr_i,
  input  logic                 fill_set_i,
  input  logic [4:0]           fill_idx_i,
  input  logic                 snes_set_i,
  input  logic [4:0]           snes_idx_i,
  output logic [NUM_LINES-1:0] flags_o
);

  logic [NUM_LINES-1:0] flags_q, flags_d, set_mask;

  assign set_mask = (NUM_LINES'(fill_set_i) << fill_idx_i) | (NUM_LINES'(snes_set_i) << snes_idx_i);
  assign flags_d  = clr_i ? '0 : flags_q | set_mask;
  assign flags_o  = flags_q;

  always_ff @(posedge clkin or negedge rst_n) begin
    if (!rst_n) flags_q <= '0;
    else        flags_q <= flags_d;
  end

endmodule

// File: rtl/gsu_cache_fill.sv
// gsu_cache_fill: fetches a missed 16-byte line from ROM into the GSU instruction cache.
// Define GSU_CACHE_CRITICAL_FIRST_EN to start at the missed byte and add crit_valid.
module gsu_cache_fill
  import gsu_pkg::*;
(
  input  logic        clkin,
  input  logic        rst_n,
  input  logic        miss_req,
  input  logic [15:0] miss_pc,
  input  logic [7:0]  pbr,
  input  logic [15:0] cbr,
  input  logic        ron,
  input  logic        cache_clear,
  input  logic        snes_flag_set,
  input  logic [4:0]  snes_flag_idx,
  output logic [23:0] ROM_BUS_ADDR,
  output logic        ROM_BUS_RRQ,
  input  logic        ROM_BUS_RDY,
  input  logic [7:0]  ROM_BUS_DI,
  output logic        cache_wr_en,
  output logic [8:0]  cache_wr_addr,
  output logic [7:0]  cache_wr_data,
  output logic [31:0] valid_flags,
  output logic        fill_busy,
`ifdef GSU_CACHE_CRITICAL_FIRST_EN
  output logic        crit_valid,
`endif
  output logic        fill_done
);

  fill_state_e state_q;
  logic [7:0]  pbr_q;
  logic [11:0] pc_q;
  logic [4:0]  cbr_q;
  logic [4:0]  line_q;
  logic [3:0]  cnt_q;
  logic [3:0]  start_cnt;
  logic [4:0]  miss_line;
  logic        last;
  logic        fill_set;
  logic        unused_bits;

`ifdef GSU_CACHE_CRITICAL_FIRST_EN
  logic [3:0] nb_q;
  assign start_cnt = miss_pc[3:0];
  assign last      = nb_q == 4'hF;
`else
  assign start_cnt = 4'h0;
  assign last      = cnt_q == 4'hF;
`endif

  assign miss_line   = line_index(miss_pc[8:4], cbr[8:4]);
  assign fill_set    = (state_q == ST_WRITE) && last && !cache_clear;
  assign unused_bits = ^{cbr[15:9], cbr[3:0], miss_pc[3:0]};

  gsu_cache_flags u_flags (
    .clkin      (clkin),
    .rst_n      (rst_n),
    .clr_i      (cache_clear),
    .fill_set_i (fill_set),
    .fill_idx_i (line_q),
    .snes_set_i (snes_flag_set),
    .snes_idx_i (snes_flag_idx),
    .flags_o    (valid_flags)
  );

  always_ff @(posedge clkin or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      pbr_q         <= '0;
      pc_q          <= '0;
      cbr_q         <= '0;
      line_q        <= '0;
      cnt_q         <= '0;
      ROM_BUS_ADDR  <= '0;
      ROM_BUS_RRQ   <= 1'b0;
      cache_wr_en   <= 1'b0;
      cache_wr_addr <= '0;
      cache_wr_data <= '0;
      fill_busy     <= 1'b0;
      fill_done     <= 1'b0;
`ifdef GSU_CACHE_CRITICAL_FIRST_EN
      nb_q          <= '0;
      crit_valid    <= 1'b0;
`endif
    end else begin
      ROM_BUS_RRQ <= 1'b0;
      cache_wr_en <= 1'b0;
      fill_done   <= 1'b0;
`ifdef GSU_CACHE_CRITICAL_FIRST_EN
      crit_valid  <= 1'b0;
`endif
      case (state_q)
        ST_IDLE: if (miss_req && !cache_clear) begin
          pbr_q  <= pbr;
          pc_q   <= miss_pc[15:4];
          cbr_q  <= cbr[8:4];
          line_q <= miss_line;
          cnt_q  <= start_cnt;
`ifdef GSU_CACHE_CRITICAL_FIRST_EN
          nb_q   <= '0;
`endif
          if (valid_flags[miss_line]) begin
            state_q   <= ST_DONE;
            fill_done <= 1'b1;
          end else begin
            state_q   <= ST_REQ;
            fill_busy <= 1'b1;
          end
        end
        ST_REQ: if (cache_clear) begin
          state_q   <= ST_IDLE;
          fill_busy <= 1'b0;
        end else if (ron) begin
          ROM_BUS_RRQ  <= 1'b1;
          ROM_BUS_ADDR <= rom_addr(pbr_q, pc_q, cnt_q);
          state_q      <= ST_WAIT;
        end
        // A flush with the data already arriving needs no drain
        ST_WAIT: if (cache_clear) begin
          state_q   <= ROM_BUS_RDY ? ST_IDLE : ST_DRAIN;
          fill_busy <= !ROM_BUS_RDY;
        end else if (ROM_BUS_RDY) begin
          cache_wr_en   <= 1'b1;
          cache_wr_addr <= cache_index(pc_q[4:0], cnt_q, {cbr_q, 4'h0});
          cache_wr_data <= ROM_BUS_DI;
          state_q       <= ST_WRITE;
`ifdef GSU_CACHE_CRITICAL_FIRST_EN
          crit_valid    <= nb_q == 4'h0;
`endif
        end
        ST_WRITE: if (cache_clear) begin
          state_q   <= ST_IDLE;
          fill_busy <= 1'b0;
        end else if (last) begin
          state_q   <= ST_DONE;
          fill_done <= 1'b1;
        end else begin
          cnt_q   <= cnt_q + 4'h1;
`ifdef GSU_CACHE_CRITICAL_FIRST_EN
          nb_q    <= nb_q + 4'h1;
`endif
          state_q <= ST_REQ;
        end
        ST_DONE: begin
          state_q   <= ST_IDLE;
          fill_busy <= 1'b0;
        end
        ST_DRAIN: if (ROM_BUS_RDY) begin
          state_q   <= ST_IDLE;
          fill_busy <= 1'b0;
        end
        default: begin
          state_q   <= ST_IDLE;
          fill_busy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_gsu_cache_fill.sv
// tb_gsu_cache_fill: random fills against a queue-based line-fill model with a random-latency ROM.
module tb_gsu_cache_fill;

  logic        clkin = 1'b0;
  logic        rst_n;
  logic        miss_req;
  logic [15:0] miss_pc;
  logic [7:0]  pbr;
  logic [15:0] cbr;
  logic        ron;
  logic        cache_clear;
  logic        snes_flag_set;
  logic [4:0]  snes_flag_idx;
  logic [23:0] ROM_BUS_ADDR;
  logic        ROM_BUS_RRQ;
  logic        ROM_BUS_RDY;
  logic [7:0]  ROM_BUS_DI;
  logic        cache_wr_en;
  logic [8:0]  cache_wr_addr;
  logic [7:0]  cache_wr_data;
  logic [31:0] valid_flags;
  logic        fill_busy;
  logic        fill_done;
`ifdef GSU_CACHE_CRITICAL_FIRST_EN
  logic        crit_valid;
  int          crit_cnt;
  int          crit_pos;
`endif

  int          checks = 0;
  int          errors = 0;
  int          rom_delay;
  int          extra_sum;
  int          done_cnt;
  logic [31:0] mflags;
  logic [23:0] rrq_addrs[$];
  logic [8:0]  wr_addrs[$];
  logic [7:0]  wr_datas[$];

  always #5 clkin = ~clkin;

  gsu_cache_fill dut (
    .clkin         (clkin),
    .rst_n         (rst_n),
    .miss_req      (miss_req),
    .miss_pc       (miss_pc),
    .pbr           (pbr),
    .cbr           (cbr),
    .ron           (ron),
    .cache_clear   (cache_clear),
    .snes_flag_set (snes_flag_set),
    .snes_flag_idx (snes_flag_idx),
    .ROM_BUS_ADDR  (ROM_BUS_ADDR),
    .ROM_BUS_RRQ   (ROM_BUS_RRQ),
    .ROM_BUS_RDY   (ROM_BUS_RDY),
    .ROM_BUS_DI    (ROM_BUS_DI),
    .cache_wr_en   (cache_wr_en),
    .cache_wr_addr (cache_wr_addr),
    .cache_wr_data (cache_wr_data),
    .valid_flags   (valid_flags),
    .fill_busy     (fill_busy),
`ifdef GSU_CACHE_CRITICAL_FIRST_EN
    .crit_valid    (crit_valid),
`endif
    .fill_done     (fill_done)
  );

  function automatic logic [7:0] rom_byte(input logic [23:0] a);
    return a[7:0] ^ a[15:8] ^ a[23:16] ^ 8'h5A;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // ROM: answers each request after rom_delay extra cycles (random 0..3 when negative)
  initial begin
    logic [23:0] a;
    int d;
    ROM_BUS_RDY = 1'b0;
    ROM_BUS_DI  = '0;
    forever begin
      @(negedge clkin);
      if (ROM_BUS_RRQ) begin
        a = ROM_BUS_ADDR;
        d = rom_delay < 0 ? int'($urandom_range(0, 3)) : rom_delay;
        extra_sum += d;
        repeat (d) @(negedge clkin);
        ROM_BUS_RDY = 1'b1;
        ROM_BUS_DI  = rom_byte(a);
        @(negedge clkin);
        ROM_BUS_RDY = 1'b0;
      end
    end
  end

  always @(negedge clkin) begin
    if (ROM_BUS_RRQ) rrq_addrs.push_back(ROM_BUS_ADDR);
    if (cache_wr_en) begin
`ifdef GSU_CACHE_CRITICAL_FIRST_EN
      if (crit_valid) begin
        crit_cnt++;
        crit_pos = wr_addrs.size();
      end
`endif
      wr_addrs.push_back(cache_wr_addr);
      wr_datas.push_back(cache_wr_data);
    end
    if (fill_done) done_cnt++;
  end

  // One miss; hold > 0 keeps ron low for that many cycles after the miss
  task automatic do_fill(input logic [7:0] p, input logic [15:0] cb, input logic [15:0] pc, input int hold);
    int line, n, start, gate_bad, lat_exp, o, ci;
    bit hit;
    logic [23:0] ea;
    line = ((int'(pc[9:4]) * 16 + int'(cb[9:0])) % 512) / 16;
    hit  = mflags[line];
`ifdef GSU_CACHE_CRITICAL_FIRST_EN
    start    = int'(pc[3:0]);
    crit_cnt = 0;
    crit_pos = -1;
`else
    start = 0;
`endif
    rrq_addrs.delete();
    wr_addrs.delete();
    wr_datas.delete();
    done_cnt  = 0;
    extra_sum = 0;
    gate_bad  = 0;
    pbr       = p;
    cbr       = cb;
    miss_pc   = pc;
    ron       = (hold == 0);
    miss_req  = 1'b1;
    n         = 0;
    do begin
      @(posedge clkin); #1;
      n++;
      miss_req = 1'b0;
      if (n <= hold && (ROM_BUS_RRQ || !fill_busy)) gate_bad++;
      if (n == hold) ron = 1'b1;
      if (hold > 0 && n == hold + 1) check("ron_first_rrq", ROM_BUS_RRQ, 1);
    end while (!fill_done && n < 3000);
    check("done_seen", fill_done, 1);
    if (hold > 0) check("ron_gate", gate_bad, 0);
    // Hit: fill_done in the cycle right after the miss cycle (two cycles in all)
    lat_exp = hit ? 1 : 16 * 3 + extra_sum + 1 + (hold > 0 ? hold - 1 : 0);
    check("latency", n, lat_exp);
    repeat (2) @(posedge clkin);
    #1;
    check("done_count", done_cnt, 1);
    check("busy_after", fill_busy, 0);
    check("rrq_count", rrq_addrs.size(), hit ? 0 : 16);
    check("wr_count", wr_addrs.size(), hit ? 0 : 16);
    if (!hit && rrq_addrs.size() == 16 && wr_addrs.size() == 16)
      for (int k = 0; k < 16; k++) begin
        o  = (start + k) % 16;
        ea = {p, pc[15:4], 4'(o)};
        ci = (int'(pc[9:4]) * 16 + o + int'(cb[9:0])) % 512;
        check("rom_addr", rrq_addrs[k], ea);
        check("wr_addr", wr_addrs[k], ci);
        check("wr_data", wr_datas[k], rom_byte(ea));
      end
    mflags[line] = 1'b1;
    check("flags", valid_flags, mflags);
`ifdef GSU_CACHE_CRITICAL_FIRST_EN
    check("crit_count", crit_cnt, hit ? 0 : 1);
    if (!hit) check("crit_pos", crit_pos, 0);
`endif
  endtask

  task automatic pulse_clear();
    cache_clear = 1'b1;
    @(posedge clkin); #1;
    cache_clear = 1'b0;
    mflags = '0;
  endtask

  task automatic snes_set(input logic [4:0] idx);
    snes_flag_set = 1'b1;
    snes_flag_idx = idx;
    @(posedge clkin); #1;
    snes_flag_set = 1'b0;
    mflags[idx] = 1'b1;
  endtask

  task automatic do_flush();
    int n;
    pulse_clear();
    rrq_addrs.delete();
    wr_addrs.delete();
    wr_datas.delete();
    done_cnt  = 0;
    rom_delay = 3;
    pbr       = 8'($urandom);
    cbr       = 16'h0;
    miss_pc   = 16'($urandom);
    ron       = 1'b1;
    miss_req  = 1'b1;
    n         = 0;
    do begin
      @(posedge clkin); #1;
      miss_req = 1'b0;
      n++;
    end while (!(ROM_BUS_RRQ && rrq_addrs.size() == 4) && n < 500);
    check("flush_reach_wait5", ROM_BUS_RRQ, 1);
    cache_clear = 1'b1;
    @(posedge clkin); #1;
    cache_clear = 1'b0;
    mflags = '0;
    check("flush_flags", valid_flags, 0);
    repeat (12) @(posedge clkin);
    #1;
    check("flush_wr_count", wr_addrs.size(), 4);
    check("flush_rrq_count", rrq_addrs.size(), 5);
    check("flush_done", done_cnt, 0);
    check("flush_busy", fill_busy, 0);
    rom_delay = -1;
  endtask

  task automatic reset_mid_fill();
    int n;
    logic [15:0] pc;
    do pc = 16'($urandom); while (mflags[pc[8:4]]);
    rom_delay = 1;
    pbr       = 8'($urandom);
    cbr       = 16'h0;
    miss_pc   = pc;
    ron       = 1'b1;
    miss_req  = 1'b1;
    n         = 0;
    do begin
      @(posedge clkin); #1;
      miss_req = 1'b0;
      n++;
    end while (!ROM_BUS_RRQ && n < 20);
    check("rst_rrq_seen", ROM_BUS_RRQ, 1);
    rst_n = 1'b0;
    #1;
    check("rst_rrq_drop", ROM_BUS_RRQ, 0);
    check("rst_busy_drop", fill_busy, 0);
    check("rst_wr_drop", cache_wr_en, 0);
    check("rst_flags", valid_flags, 0);
    @(posedge clkin); #1;
    rst_n  = 1'b1;
    mflags = '0;
    repeat (8) @(posedge clkin);
    #1;
    rom_delay = -1;
  endtask

  initial begin
    logic [15:0] lpc, lcb;
    rst_n         = 1'b0;
    miss_req      = 1'b0;
    miss_pc       = '0;
    pbr           = '0;
    cbr           = '0;
    ron           = 1'b1;
    cache_clear   = 1'b0;
    snes_flag_set = 1'b0;
    snes_flag_idx = '0;
    rom_delay     = -1;
    extra_sum     = 0;
    done_cnt      = 0;
    mflags        = '0;
    repeat (3) @(posedge clkin);
    #1;
    check("rst_flags0", valid_flags, 0);
    check("rst_rrq0", ROM_BUS_RRQ, 0);
    check("rst_addr0", ROM_BUS_ADDR, 0);
    check("rst_wr0", cache_wr_en, 0);
    check("rst_busy0", fill_busy, 0);
    check("rst_done0", fill_done, 0);
    rst_n = 1'b1;
    @(posedge clkin); #1;

    rom_delay = 2;
    do_fill(8'h01, 16'h0000, 16'h8023, 0);
    check("basic_line2", valid_flags[2], 1);
    rom_delay = -1;
    do_fill(8'h7E, 16'h01F0, 16'h0005, 0);
    check("cbr_line31", valid_flags[31], 1);

    lpc = 16'h8023;
    lcb = 16'h0;
    for (int i = 0; i < 12; i++) begin
      if ($urandom_range(0, 2) == 0) snes_set(5'($urandom));
      if ($urandom_range(0, 3) != 0) begin
        lpc = 16'($urandom);
        lcb = 16'($urandom) & 16'hFFF0;
      end
      do_fill(8'($urandom), lcb, lpc, 0);
    end

    pulse_clear();
    do_fill(8'($urandom), 16'($urandom) & 16'hFFF0, 16'($urandom), 50);

    do_flush();
    do_fill(8'($urandom), 16'h0, 16'($urandom), 0);

    snes_set(5'd4);
    do_fill(8'($urandom), 16'h0, (16'($urandom) & 16'hFC0F) | 16'h0040, 0);

    snes_flag_set = 1'b1;
    snes_flag_idx = 5'($urandom);
    cache_clear   = 1'b1;
    @(posedge clkin); #1;
    snes_flag_set = 1'b0;
    cache_clear   = 1'b0;
    mflags        = '0;
    check("clear_beats_set", valid_flags, 0);

`ifdef GSU_CACHE_CRITICAL_FIRST_EN
    do_fill(8'h01, 16'h0000, 16'h800A, 0);
`endif

    do_fill(8'($urandom), 16'($urandom) & 16'hFFF0, 16'($urandom), 0);
    reset_mid_fill();
    do_fill(8'($urandom), 16'($urandom) & 16'hFFF0, 16'($urandom), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/gsu_cache_fill.md
Name: gsu_cache_fill

Overview:
- Fill engine upstream of the GSU core's 512-byte instruction cache.
- Handles a miss on the line at PC: fetches the 16-byte line from Game Pak ROM over the shared ROM bus, writes it into the cache RAM, and sets that line's valid flag.
- Owns the 32 line-valid flags. The core reads them; the SNES-side cache port also sets them on writes to a line's last byte.

Parameters:
- LINE_BYTES, 16, bytes per cache line; fixed, sets the 4-bit byte counter.
- NUM_LINES, 32, cache lines; sets the 5-bit flag index.

Ports:
- clkin  in  1  system clock.
- rst_n  in  1  reset, asynchronous, active-low.
- miss_req  in  1  one-cycle pulse from core: line containing miss_pc is not valid.
- miss_pc  in  16  R15 value at the miss.
- pbr  in  8  program bank register.
- cbr  in  16  cache base register; bits [3:0] are zero.
- ron  in  1  GSU owns the ROM bus (SCMR.RON).
- cache_clear  in  1  flush pulse (CBR write or CACHE/LJMP).
- snes_flag_set  in  1  SNES wrote byte 15 of a line.
- snes_flag_idx  in  5  line index of that SNES write.
- ROM_BUS_ADDR  out  24  ROM byte address.
- ROM_BUS_RRQ  out  1  one-cycle read request.
- ROM_BUS_RDY  in  1  read data valid on ROM_BUS_DI.
- ROM_BUS_DI  in  8  ROM read data.
- cache_wr_en  out  1  cache RAM write strobe.
- cache_wr_addr  out  9  cache RAM byte address.
- cache_wr_data  out  8  cache RAM write data.
- valid_flags  out  32  per-line valid bits.
- fill_busy  out  1  fill in progress.
- fill_done  out  1  one-cycle pulse when the line becomes valid.

Behaviour:
- Reset values: all outputs 0; valid_flags = 0; state IDLE.
- Address arithmetic:
  - cache index = ({miss_pc[9:4], cnt} + cbr[9:0]) & 0x1FF.
  - line = cache index [8:4].
  - ROM address = {pbr, miss_pc[15:4], cnt}.
  - cnt is the 4-bit byte counter and wraps 15 -> 0.
- State machine: IDLE, REQ, WAIT, WRITE, DONE, DRAIN.
- IDLE:
  - On miss_req, latch pbr, miss_pc[15:4] and the line index, cnt = 0.
  - If the line's flag is already set: go to DONE, with no bus traffic.
  - Otherwise: go to REQ, fill_busy = 1.
- REQ:
  - If ron = 1, assert ROM_BUS_RRQ for exactly one cycle with ROM_BUS_ADDR valid, then go to WAIT.
  - If ron = 0, hold in REQ with no request.
- WAIT:
  - ROM_BUS_ADDR stays stable.
  - On ROM_BUS_RDY, register ROM_BUS_DI and go to WRITE.
- WRITE:
  - cache_wr_en = 1 for one cycle.
  - If cnt == 15: go to DONE. Otherwise cnt++ and go to REQ.
- DONE:
  - Set valid_flags[line] and pulse fill_done for one cycle.
  - Clear fill_busy and return to IDLE.
  - Latency: miss to fill_done = 16 × (3 + ROM wait) cycles, plus 1.
  - Hit-on-miss case (flag already set) = 2 cycles.
- miss_req while fill_busy: ignored. The core must re-raise it after fill_done if still missing.
- cache_clear:
  - Zeroes all flags the same cycle. Clear has priority over any flag set in that cycle.
  - In REQ or WRITE: abort to IDLE, no fill_done, no further writes.
  - In WAIT: go to DRAIN. DRAIN waits for ROM_BUS_RDY, discards the data, then goes to IDLE, so the bus request is never orphaned.
- snes_flag_set: sets valid_flags[snes_flag_idx]. This is an OR with the fill engine's DONE set, so the same index in the same cycle is harmless.
- Reset mid-fill: immediate return to IDLE; RRQ and write strobe drop asynchronously.

Optional Feature:
- Macro: GSU_CACHE_CRITICAL_FIRST_EN.
- When defined:
  - Fill starts at cnt = miss_pc[3:0] and wraps 15 -> 0 until 16 bytes are written.
  - Extra output crit_valid pulses one cycle, coincident with the first cache_wr_en, so the core can start early.
  - A byte counter separate from cnt terminates the fill.
- When undefined: fill always starts at offset 0; crit_valid does not exist.

Decomposition:
- Shared package gsu_pkg:
  - state encoding constants (one-hot, 8-bit, matching core style);
  - LINE_BYTES, NUM_LINES;
  - function resolving cache index from pc and cbr, shared with the core.
- Sub-module gsu_cache_flags: the 32-bit valid register with set/clear/priority logic.

Test Plan:
- Basic fill:
  - Stimulus: pbr=0x01, cbr=0, miss_pc=0x8023, ron=1, RDY 2 cycles after each RRQ.
  - Response: 16 requests at 0x018020..0x01802F; writes to cache addresses 0x020..0x02F; valid_flags[2]=1; one fill_done.
- CBR offset:
  - Stimulus: cbr=0x01F0, miss_pc=0x0005.
  - Response: writes to 0x1F0..0x1FF; flag index 31.
- ron gating:
  - Stimulus: ron=0 for 50 cycles after miss_req.
  - Response: no RRQ, fill_busy=1; first RRQ the cycle after ron rises.
- Flush in WAIT:
  - Stimulus: cache_clear during the 5th WAIT.
  - Response: flags=0; RDY consumed in DRAIN; no write, no fill_done; IDLE afterwards.
- Already valid:
  - Stimulus: snes_flag_set idx 4, then miss_req for a PC in line 4.
  - Response: fill_done after 2 cycles, zero RRQ.
- Critical first (macro defined):
  - Stimulus: miss_pc=0x800A.
  - Response: first RRQ address ...0A, then 0B..0F, then 00..09; crit_valid on the first write.
